// File: rtl/cdc_pkg.sv
// Shared types and constants for the toggle request/acknowledge CDC source.
package cdc_pkg;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } cdc_state_e;

   localparam int CDC_DROP_CNT_W = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CDC_DROP_CNT_W-1:0] sat_inc(input logic [CDC_DROP_CNT_W-1:0] v);
      logic [CDC_DROP_CNT_W-1:0] r;
      if (v == {CDC_DROP_CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(CDC_DROP_CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; synchronous active-low reset.
module sync_ff #(
   parameter int   SYNC_WIDTH = 2,
   parameter logic RESET_VAL  = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_WIDTH-1:0] chain_q;
   logic [SYNC_WIDTH-1:0] chain_d;

   assign chain_d = {chain_q[SYNC_WIDTH-2:0], d_i};

   // Shift the asynchronous level through the flop chain.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         chain_q <= {SYNC_WIDTH{RESET_VAL}};
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q_o = chain_q[SYNC_WIDTH-1];

endmodule

// File: rtl/cdc_req_src.sv
// Source half of a two-phase toggle req/ack crossing. Optional refused-offer
// counter enabled by macro CDC_REQ_SRC_DROP_CNT_EN.
module cdc_req_src
   import cdc_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ACK_SYNC_WIDTH = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      valid_i,
   input  logic [DATA_WIDTH-1:0]     data_i,
   output logic                      ready_o,
   output logic                      req_o,
   output logic [DATA_WIDTH-1:0]     data_o,
   input  logic                      ack_i,
   output logic                      done_o,
   output logic [CDC_DROP_CNT_W-1:0] drop_cnt_o
);

   cdc_state_e            state_q, state_d;
   logic                  req_q, req_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  ack_s;
   logic                  done_s;
   logic                  ready_s;
   logic                  accept_s;

   sync_ff #(
      .SYNC_WIDTH (ACK_SYNC_WIDTH),
      .RESET_VAL  (1'b0)
   ) u_ack_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (ack_i),
      .q_o    (ack_s)
   );

   // Transfer completes once the returned toggle parity matches the request.
   assign done_s   = (state_q == WAIT_ACK) && (ack_s == req_q);
   assign ready_s  = (state_q == IDLE) || done_s;
   assign accept_s = valid_i && ready_s;

   // Next state: an accept in the done cycle chains straight into the next transfer.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = WAIT_ACK;
               req_d   = ~req_q;
               data_d  = data_i;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_ACK: begin
            if (accept_s) begin
               state_d = WAIT_ACK;
               req_d   = ~req_q;
               data_d  = data_i;
            end else if (done_s) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_ACK;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control FSM and the registered crossing outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         data_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         data_q  <= data_d;
      end
   end

   assign req_o   = req_q;
   assign data_o  = data_q;
   assign done_o  = done_s;
   assign ready_o = ready_s;

`ifdef CDC_REQ_SRC_DROP_CNT_EN
   logic [CDC_DROP_CNT_W-1:0] drop_q, drop_d;

   assign drop_d = (valid_i && !ready_s) ? sat_inc(drop_q) : drop_q;

   // Saturating count of offers refused while a transfer is outstanding.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         drop_q <= {CDC_DROP_CNT_W{1'b0}};
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt_o = drop_q;
`else
   assign drop_cnt_o = {CDC_DROP_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cdc_req_src.sv
// Directed scoreboard bench for cdc_req_src with DATA_WIDTH=8, ACK_SYNC_WIDTH=2.
module tb_cdc_req_src;

   localparam int DW = 8;
   localparam int SW = 2;
`ifdef CDC_REQ_SRC_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid;
   logic [DW-1:0] din;
   logic          ready;
   logic          req;
   logic [DW-1:0] dout;
   logic          ack;
   logic          done;
   logic [7:0]    drop_cnt;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q[$];

   cdc_req_src #(.DATA_WIDTH(DW), .ACK_SYNC_WIDTH(SW)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .valid_i    (valid),
      .data_i     (din),
      .ready_o    (ready),
      .req_o      (req),
      .data_o     (dout),
      .ack_i      (ack),
      .done_o     (done),
      .drop_cnt_o (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_data(input string tag);
      logic [DW-1:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, dout);
      end else begin
         e = exp_q.pop_front();
         check(tag, {24'd0, dout}, {24'd0, e});
      end
   endtask

   task automatic offer(input logic [DW-1:0] d);
      valid = 1'b1;
      din   = d;
      exp_q.push_back(d);
   endtask

   task automatic wait_done(input string tag, input int exp_cycles);
      int c = 0;
      while (done !== 1'b1 && c < 20) begin
         tick();
         c++;
      end
      check(tag, c, exp_cycles);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid = 1'b0;
      ack   = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      valid = 1'b0;
      din   = 8'h00;
      ack   = 1'b0;

      // Reset and idle
      do_reset();
      for (int i = 0; i < 10; i++) begin
         check("idle_state", {28'd0, ready, req, done, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
         check("idle_data", {16'd0, dout, drop_cnt}, 32'd0);
         tick();
      end

      // Single transfer of 0xA5
      offer(8'hA5);
      check("single_ready_pre", {31'd0, ready}, 32'd1);
      tick();
      valid = 1'b0;
      check("single_req", {31'd0, req}, 32'd1);
      check_data("single_data");
      check("single_ready_busy", {31'd0, ready}, 32'd0);
      tick();
      tick();
      check("single_no_done", {31'd0, done}, 32'd0);
      ack = 1'b1;
      tick();
      check("single_done_early", {31'd0, done}, 32'd0);
      tick();
      check("single_done", {31'd0, done}, 32'd1);
      check("single_ready_done", {31'd0, ready}, 32'd1);
      tick();
      check("single_done_pulse", {31'd0, done}, 32'd0);
      check("single_ready_after", {31'd0, ready}, 32'd1);

      // Back-to-back 0x11 then 0x22
      do_reset();
      offer(8'h11);
      tick();
      check("b2b_req1", {31'd0, req}, 32'd1);
      check_data("b2b_data1");
      din = 8'h22;
      ack = 1'b1;
      tick();
      check("b2b_wait", {31'd0, done}, 32'd0);
      tick();
      check("b2b_done1", {30'd0, done, ready}, 32'd3);
      exp_q.push_back(8'h22);
      tick();
      valid = 1'b0;
      check("b2b_req2", {31'd0, req}, 32'd0);
      check_data("b2b_data2");
      check("b2b_no_idle", {30'd0, done, ready}, 32'd0);
      ack = 1'b0;
      wait_done("b2b_done2_lat", 2);
      check("b2b_req2_hold", {31'd0, req}, 32'd0);
      tick();
      check("b2b_idle", {30'd0, done, ready}, 32'd1);

      // Stall: refused 0x33 while 0x44 is outstanding
      do_reset();
      offer(8'h44);
      tick();
      check_data("stall_first");
      din = 8'h33;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_data_hold", {24'd0, dout}, 32'h44);
         check("stall_ready", {31'd0, ready}, 32'd0);
      end
      valid = 1'b0;
      check("stall_drop", {24'd0, drop_cnt}, DROP_EN ? 32'd5 : 32'd0);
      ack = 1'b1;
      wait_done("stall_done_lat", 2);
      tick();
      check("stall_drop_hold", {24'd0, drop_cnt}, DROP_EN ? 32'd5 : 32'd0);

      // Reset during WAIT_ACK aborts the transfer
      offer(8'h55);
      tick();
      valid = 1'b0;
      check("abort_req", {31'd0, req}, 32'd0);
      check_data("abort_data");
      rst_n = 1'b0;
      ack   = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_state", {30'd0, req, ready}, 32'd1);
      check("abort_data_clr", {24'd0, dout}, 32'd0);
      check("abort_drop_clr", {24'd0, drop_cnt}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         check("abort_no_done", {31'd0, done}, 32'd0);
         tick();
      end

      // Saturation of the refused-offer counter
      offer(8'h66);
      tick();
      check_data("sat_data");
      din = 8'h77;
      for (int i = 0; i < 300; i++) begin
         tick();
      end
      check("sat_255", {24'd0, drop_cnt}, DROP_EN ? 32'd255 : 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      check("sat_hold", {24'd0, drop_cnt}, DROP_EN ? 32'd255 : 32'd0);
      check("sat_data_hold", {24'd0, dout}, 32'h66);
      valid = 1'b0;

      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
